radix2_butterfly_pipe: RTL and testbench

- Pipelined radix-2 decimation-in-time butterfly.
- Computes X = A + W·B and Y = A − W·B on complex fixed-point operands, with W a per-beat twiddle input.
- Selectable divide-by-2 scaling with rounding, output saturation, sticky overflow flag, and a valid/ready handshake with full-pipeline stall.
- Instantiated once per stage of the parallel DIT FFT. Stage 1 runs in twiddle-bypass mode (W = 1); later stages take W from the twiddle ROM.

---
 rtl/radix2_butterfly_pipe.sv | 196 +++++++++++++++++++
 tb/tb_radix2_butterfly_pipe.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radix2_butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly: X = A + W*B, Y = A - W*B on complex fixed point,
// with optional round-half-up halving, per-component saturation and a sticky overflow flag.
module radix2_butterfly_pipe #(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] re_a,
  input  logic [DW-1:0] im_a,
  input  logic [DW-1:0] re_b,
  input  logic [DW-1:0] im_b,
  input  logic [TW-1:0] tw_re,
  input  logic [TW-1:0] tw_im,
  input  logic          tw_bypass,
  input  logic          scale_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] re_x,
  output logic [DW-1:0] im_x,
  output logic [DW-1:0] re_y,
  output logic [DW-1:0] im_y,
  input  logic          ovf_clr,
  output logic          ovf_sticky
);
  localparam int PW = DW + TW + 1;
  localparam int SW = DW + 2;
  localparam int EW = DW + 3;
  localparam logic signed [PW-1:0] RND_HALF = PW'(1) <<< (TW - 2);
  localparam logic signed [EW-1:0] SAT_MAX  = {{(EW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN  = {{(EW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic signed [SW-1:0] round_prod(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] r;
    r = (p + RND_HALF) >>> (TW - 1);
    return r[SW-1:0];
  endfunction

  function automatic logic signed [EW-1:0] scale_sum(input logic signed [EW-1:0] s,
                                                     input logic en);
    logic signed [EW-1:0] r;
    r = s;
    if (en) r = (s + EW'(1)) >>> 1;
    return r;
  endfunction

  function automatic logic is_sat(input logic signed [EW-1:0] s);
    return (s > SAT_MAX) || (s < SAT_MIN);
  endfunction

  function automatic logic [DW-1:0] saturate(input logic signed [EW-1:0] s);
    logic [DW-1:0] r;
    if (s > SAT_MAX)      r = {1'b0, {(DW-1){1'b1}}};
    else if (s < SAT_MIN) r = {1'b1, {(DW-1){1'b0}}};
    else                  r = s[DW-1:0];
    return r;
  endfunction

  logic advance;

  logic                 vld_p1_q, vld_p1_d;
  logic signed [DW-1:0] a_re_p1_q, a_re_p1_d, a_im_p1_q, a_im_p1_d;
  logic signed [DW-1:0] b_re_p1_q, b_re_p1_d, b_im_p1_q, b_im_p1_d;
  logic signed [TW-1:0] w_re_p1_q, w_re_p1_d, w_im_p1_q, w_im_p1_d;
  logic                 byp_p1_q, byp_p1_d, scl_p1_q, scl_p1_d;

  logic                 vld_p2_q, vld_p2_d;
  logic signed [DW-1:0] a_re_p2_q, a_re_p2_d, a_im_p2_q, a_im_p2_d;
  logic signed [SW-1:0] p_re_p2_q, p_re_p2_d, p_im_p2_q, p_im_p2_d;
  logic                 scl_p2_q, scl_p2_d;

  logic                 vld_p3_q, vld_p3_d;
  logic [DW-1:0]        x_re_p3_q, x_re_p3_d, x_im_p3_q, x_im_p3_d;
  logic [DW-1:0]        y_re_p3_q, y_re_p3_d, y_im_p3_q, y_im_p3_d;
  logic                 sat_p3_q, sat_p3_d;
  logic                 ovf_q, ovf_d;

  logic signed [PW-1:0] br_w, bi_w, wr_w, wi_w, pr_full, pi_full;
  logic signed [EW-1:0] sx_re, sx_im, sy_re, sy_im;

  assign advance  = !vld_p3_q || out_ready;
  assign in_ready = advance;

  // S1 -> S2: full-precision complex product; PW bits keep (-1,-1)*(min,min) from wrapping
  assign br_w    = PW'(b_re_p1_q);
  assign bi_w    = PW'(b_im_p1_q);
  assign wr_w    = PW'(w_re_p1_q);
  assign wi_w    = PW'(w_im_p1_q);
  assign pr_full = br_w * wr_w - bi_w * wi_w;
  assign pi_full = br_w * wi_w + bi_w * wr_w;

  // S2 -> S3: butterfly add/sub, optional halving, then saturation
  assign sx_re = scale_sum(EW'(a_re_p2_q) + EW'(p_re_p2_q), scl_p2_q);
  assign sx_im = scale_sum(EW'(a_im_p2_q) + EW'(p_im_p2_q), scl_p2_q);
  assign sy_re = scale_sum(EW'(a_re_p2_q) - EW'(p_re_p2_q), scl_p2_q);
  assign sy_im = scale_sum(EW'(a_im_p2_q) - EW'(p_im_p2_q), scl_p2_q);

  always_comb begin
    vld_p1_d  = vld_p1_q;
    a_re_p1_d = a_re_p1_q;
    a_im_p1_d = a_im_p1_q;
    b_re_p1_d = b_re_p1_q;
    b_im_p1_d = b_im_p1_q;
    w_re_p1_d = w_re_p1_q;
    w_im_p1_d = w_im_p1_q;
    byp_p1_d  = byp_p1_q;
    scl_p1_d  = scl_p1_q;
    vld_p2_d  = vld_p2_q;
    a_re_p2_d = a_re_p2_q;
    a_im_p2_d = a_im_p2_q;
    p_re_p2_d = p_re_p2_q;
    p_im_p2_d = p_im_p2_q;
    scl_p2_d  = scl_p2_q;
    vld_p3_d  = vld_p3_q;
    x_re_p3_d = x_re_p3_q;
    x_im_p3_d = x_im_p3_q;
    y_re_p3_d = y_re_p3_q;
    y_im_p3_d = y_im_p3_q;
    sat_p3_d  = sat_p3_q;
    // A held beat keeps its saturation bit; it only reaches the flag on the transfer edge.
    ovf_d     = (ovf_q && !ovf_clr) || (vld_p3_q && out_ready && sat_p3_q);
    if (advance) begin
      vld_p1_d  = in_valid;
      a_re_p1_d = signed'(re_a);
      a_im_p1_d = signed'(im_a);
      b_re_p1_d = signed'(re_b);
      b_im_p1_d = signed'(im_b);
      w_re_p1_d = signed'(tw_re);
      w_im_p1_d = signed'(tw_im);
      byp_p1_d  = tw_bypass;
      scl_p1_d  = scale_en;
      vld_p2_d  = vld_p1_q;
      a_re_p2_d = a_re_p1_q;
      a_im_p2_d = a_im_p1_q;
      p_re_p2_d = byp_p1_q ? SW'(b_re_p1_q) : round_prod(pr_full);
      p_im_p2_d = byp_p1_q ? SW'(b_im_p1_q) : round_prod(pi_full);
      scl_p2_d  = scl_p1_q;
      vld_p3_d  = vld_p2_q;
      x_re_p3_d = saturate(sx_re);
      x_im_p3_d = saturate(sx_im);
      y_re_p3_d = saturate(sy_re);
      y_im_p3_d = saturate(sy_im);
      sat_p3_d  = is_sat(sx_re) || is_sat(sx_im) || is_sat(sy_re) || is_sat(sy_im);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      vld_p3_q  <= 1'b0;
      x_re_p3_q <= '0;
      x_im_p3_q <= '0;
      y_re_p3_q <= '0;
      y_im_p3_q <= '0;
      sat_p3_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      vld_p3_q  <= vld_p3_d;
      x_re_p3_q <= x_re_p3_d;
      x_im_p3_q <= x_im_p3_d;
      y_re_p3_q <= y_re_p3_d;
      y_im_p3_q <= y_im_p3_d;
      sat_p3_q  <= sat_p3_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    a_re_p1_q <= a_re_p1_d;
    a_im_p1_q <= a_im_p1_d;
    b_re_p1_q <= b_re_p1_d;
    b_im_p1_q <= b_im_p1_d;
    w_re_p1_q <= w_re_p1_d;
    w_im_p1_q <= w_im_p1_d;
    byp_p1_q  <= byp_p1_d;
    scl_p1_q  <= scl_p1_d;
    a_re_p2_q <= a_re_p2_d;
    a_im_p2_q <= a_im_p2_d;
    p_re_p2_q <= p_re_p2_d;
    p_im_p2_q <= p_im_p2_d;
    scl_p2_q  <= scl_p2_d;
  end

  assign out_valid  = vld_p3_q;
  assign re_x       = x_re_p3_q;
  assign im_x       = x_im_p3_q;
  assign re_y       = y_re_p3_q;
  assign im_y       = y_im_p3_q;
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_radix2_butterfly_pipe.sv
// Bench for radix2_butterfly_pipe: directed literal cases plus randomized traffic
// scored against an arithmetic reference model and a queue of expected beats.
module tb_radix2_butterfly_pipe;
  localparam int DW = 16;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, tw_bypass, scale_en;
  logic          out_valid, out_ready, ovf_clr, ovf_sticky;
  logic [DW-1:0] re_a, im_a, re_b, im_b, re_x, im_x, re_y, im_y;
  logic [TW-1:0] tw_re, tw_im;

  always #5 clk = ~clk;

  radix2_butterfly_pipe #(.DW(DW), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .re_a(re_a), .im_a(im_a), .re_b(re_b), .im_b(im_b),
    .tw_re(tw_re), .tw_im(tw_im), .tw_bypass(tw_bypass), .scale_en(scale_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .re_x(re_x), .im_x(im_x), .re_y(re_y), .im_y(im_y),
    .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky)
  );

  typedef struct {
    logic [DW-1:0] xr, xi, yr, yi;
    bit            sat;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_xfer  = 0;
  bit   m_ovf   = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  function automatic logic [DW-1:0] e16(input int v);
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] lo(input longint v);
    return v[DW-1:0];
  endfunction

  // Reference: exact integer arithmetic, floor(v + 1/2) rounding, clamp to DW bits.
  function automatic exp_t model(input int ar, input int ai, input int br, input int bi,
                                 input int wr, input int wi, input bit byp, input bit scl);
    exp_t   e;
    longint pr, pi, lim, c;
    longint s[4];
    lim = longint'(1) << (DW - 1);
    if (byp) begin
      pr = br;
      pi = bi;
    end else begin
      pr = (longint'(br) * wr - longint'(bi) * wi + (longint'(1) << (TW - 2))) >>> (TW - 1);
      pi = (longint'(br) * wi + longint'(bi) * wr + (longint'(1) << (TW - 2))) >>> (TW - 1);
    end
    s[0] = ar + pr;
    s[1] = ai + pi;
    s[2] = ar - pr;
    s[3] = ai - pi;
    e.sat = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (scl) s[k] = (s[k] + 1) >>> 1;
      c = s[k];
      if (c > lim - 1) c = lim - 1;
      if (c < -lim)    c = -lim;
      if (c != s[k]) e.sat = 1'b1;
      s[k] = c;
    end
    e.xr = lo(s[0]);
    e.xi = lo(s[1]);
    e.yr = lo(s[2]);
    e.yi = lo(s[3]);
    return e;
  endfunction

  // Everything is decided at the falling edge for the rising edge that follows.
  always @(negedge clk) begin : scoreboard
    bit nxt;
    chk("ovf_sticky", ovf_sticky, m_ovf);
    chk("in_ready", in_ready, !out_valid || out_ready);
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", out_valid, 0);
      end else begin
        chk("re_x", re_x, exp_q[0].xr);
        chk("im_x", im_x, exp_q[0].xi);
        chk("re_y", re_y, exp_q[0].yr);
        chk("im_y", im_y, exp_q[0].yi);
      end
    end
    if (rst_n !== 1'b1) begin
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      nxt = m_ovf && !ovf_clr;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        if (exp_q[0].sat) nxt = 1'b1;
        void'(exp_q.pop_front());
        n_xfer++;
      end
      m_ovf = nxt;
      if (in_valid && in_ready)
        exp_q.push_back(model($signed(re_a), $signed(im_a), $signed(re_b), $signed(im_b),
                              $signed(tw_re), $signed(tw_im), tw_bypass, scale_en));
    end
  end

  function automatic int rnd_d();
    logic [DW-1:0] t;
    t = DW'($urandom);
    case ($urandom_range(0, 5))
      0:       return (1 << (DW - 1)) - 1;
      1:       return -(1 << (DW - 1));
      default: return int'($signed(t));
    endcase
  endfunction

  function automatic int rnd_w();
    logic [TW-1:0] t;
    t = TW'($urandom);
    case ($urandom_range(0, 5))
      0:       return (1 << (TW - 1)) - 1;
      1:       return -(1 << (TW - 1));
      default: return int'($signed(t));
    endcase
  endfunction

  task automatic set_beat(input int ar, input int ai, input int br, input int bi,
                          input int wr, input int wi, input bit byp, input bit scl);
    re_a = ar[DW-1:0];
    im_a = ai[DW-1:0];
    re_b = br[DW-1:0];
    im_b = bi[DW-1:0];
    tw_re = wr[TW-1:0];
    tw_im = wi[TW-1:0];
    tw_bypass = byp;
    scale_en = scl;
    in_valid = 1'b1;
  endtask

  // Returns one time unit after the accepting edge.
  task automatic drive_beat(input int ar, input int ai, input int br, input int bi,
                            input int wr, input int wi, input bit byp, input bit scl);
    bit ok;
    ok = 1'b0;
    set_beat(ar, ai, br, bi, wr, wi, byp, scl);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    chk("accept", ok, 1);
    in_valid = 1'b0;
  endtask

  task automatic drive_rnd();
    drive_beat(rnd_d(), rnd_d(), rnd_d(), rnd_d(), rnd_w(), rnd_w(), 1'($urandom), 1'($urandom));
  endtask

  task automatic run_one(input string tag, input int ar, input int ai, input int br, input int bi,
                         input int wr, input int wi, input bit byp, input bit scl,
                         input int exr, input int exi, input int eyr, input int eyi);
    int lat;
    lat = 0;
    drive_beat(ar, ai, br, bi, wr, wi, byp, scl);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_re_x"}, re_x, e16(exr));
    chk({tag, "_im_x"}, im_x, e16(exi));
    chk({tag, "_re_y"}, re_y, e16(eyr));
    chk({tag, "_im_y"}, im_y, e16(eyi));
    @(posedge clk);
    #1;
  endtask

  task automatic check_at_negedge(input string name, input logic [63:0] want_ovf);
    @(negedge clk);
    chk(name, ovf_sticky, want_ovf);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int x0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    re_a = '0; im_a = '0; re_b = '0; im_b = '0;
    tw_re = '0; tw_im = '0; tw_bypass = 1'b0; scale_en = 1'b0;
    out_ready = 1'b1;
    ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_re_x", re_x, 0);
    chk("rst_im_x", im_x, 0);
    chk("rst_re_y", re_y, 0);
    chk("rst_im_y", im_y, 0);
    chk("rst_ovf", ovf_sticky, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_one("bypass",  100, -50,  30,  20,     0,      0, 1, 0,  130,  -30,  70,  -70);
    run_one("w_mj",      0,   0, 1000, 200,    0, -32768, 0, 0,  200, -1000, -200, 1000);
    run_one("w_half",    0,   0,   3,   0, 16384,      0, 0, 0,    2,    0,  -2,    0);
    run_one("scl_rnd",   3,  -3,   0,   0,     0,      0, 1, 1,    2,   -1,   2,   -1);
    run_one("scl_max", 32767, 32767, 32767, 32767, 0, 0, 1, 1, 32767, 32767, 0, 0);
    check_at_negedge("ovf_clean", 0);

    run_one("sat", 32767, -32768, 1, -1, 0, 0, 1, 0, 32767, -32768, 32766, -32767);
    check_at_negedge("ovf_set", 1);

    // Clear lands on the same edge as another saturating transfer: set must win.
    drive_beat(32767, -32768, 1, -1, 0, 0, 1, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check_at_negedge("ovf_set_wins", 1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check_at_negedge("ovf_cleared", 0);

    run_one("corner", 0, 0, -32768, -32768, -32768, -32768, 0, 0, 0, 32767, 0, -32768);
    check_at_negedge("corner_ovf", 1);

    x0 = n_xfer;
    fork
      begin
        for (int i = 0; i < 6; i++) drive_rnd();
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (12) @(posedge clk);
    #1;
    chk("stream_count", n_xfer - x0, 6);
    chk("stream_drained", exp_q.size(), 0);

    out_ready = 1'b0;
    repeat (3) drive_rnd();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_ovf", ovf_sticky, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("midrst_no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;

    for (int c = 0; c < 400; c++) begin
      set_beat(rnd_d(), rnd_d(), rnd_d(), rnd_d(), rnd_w(), rnd_w(), 1'($urandom), 1'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    ovf_clr = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("final_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
